// File: rtl/f2i_pipe.sv
// Three-stage pipelined float-to-integer converter: decode, align, round/range.
// Parametrised float/int widths, four rounding modes, signed/unsigned range, sticky flags.
module f2i_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int INT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [1:0]           rm,
    input  logic                 is_unsigned,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INT_W-1:0]     d,
    output logic                 p_lost,
    output logic                 denorm,
    output logic                 invalid,
    input  logic                 flag_clr,
    output logic                 sticky_invalid,
    output logic                 sticky_inexact
);
    localparam int BIAS = 2**(EXP_W-1) - 1;
    localparam int EW   = ((EXP_W > 8) ? EXP_W : 8) + 2;
    localparam int SW   = MAN_W + 1;
    localparam int F    = MAN_W + 3;
    localparam int TW   = INT_W + 1 + F;
    localparam int SHW  = $clog2(TW);
    localparam logic signed [EW-1:0] E_BIG  = EW'(INT_W + 1);
    localparam logic signed [EW-1:0] E_TINY = EW'(-2);
    localparam logic [INT_W-1:0] SMAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] SMIN = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic [1:0] RM_RNE = 2'b00, RM_RTZ = 2'b01, RM_RDN = 2'b10, RM_RUP = 2'b11;

    // Handshake: one global advance enable. A stage slot moves forward whenever the
    // output slot is empty or being taken (out_valid & out_ready); an operand is
    // taken on in_valid & in_ready. Bubbles travel with the pipe and are not collapsed.
    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // ---------------- S1: decode/classify ----------------
    logic                 a_sign;
    logic [EXP_W-1:0]     a_exp;
    logic [MAN_W-1:0]     a_frac;
    logic                 s1_zero_d, s1_sub_d, s1_inf_d, s1_nan_d;
    logic signed [EW-1:0] s1_exp_d;

    assign {a_sign, a_exp, a_frac} = a;
    assign s1_zero_d = (a_exp == '0) & ~(|a_frac);
    assign s1_sub_d  = (a_exp == '0) &  (|a_frac);
    assign s1_inf_d  = (&a_exp) & ~(|a_frac);
    assign s1_nan_d  = (&a_exp) &  (|a_frac);
    assign s1_exp_d  = EW'(a_exp) - EW'(BIAS);

    logic                 s1_v_q, s1_sign_q, s1_zero_q, s1_sub_q, s1_inf_q, s1_nan_q, s1_uns_q;
    logic signed [EW-1:0] s1_exp_q;
    logic [SW-1:0]        s1_sig_q;
    logic [1:0]           s1_rm_q;

    // ---------------- S2: align ----------------
    // Fixed point with F fraction bits: value = sig << (exp+3). Valid for exp in [-2, INT_W].
    logic [SHW-1:0]   sh;
    logic [TW-1:0]    fix;
    logic [INT_W:0]   s2_mag_d;
    logic             s2_g_d, s2_s_d, s2_ovf_d;

    assign sh  = SHW'(s1_exp_q + EW'(3));
    assign fix = TW'(s1_sig_q) << sh;

    always_comb begin
        s2_mag_d = '0;
        s2_g_d   = 1'b0;
        s2_s_d   = 1'b0;
        s2_ovf_d = 1'b0;
        if (s1_sub_q) begin
            s2_s_d = 1'b1;
        end else if (s1_zero_q || s1_inf_q || s1_nan_q) begin
            s2_s_d = 1'b0;
        end else if (s1_exp_q >= E_BIG) begin
            s2_ovf_d = 1'b1;
        end else if (s1_exp_q < E_TINY) begin
            s2_s_d = 1'b1;
        end else begin
            s2_mag_d = fix[TW-1:F];
            s2_g_d   = fix[F-1];
            s2_s_d   = |fix[F-2:0];
        end
    end

    logic           s2_v_q, s2_sign_q, s2_g_q, s2_s_q, s2_ovf_q;
    logic           s2_zero_q, s2_sub_q, s2_inf_q, s2_nan_q, s2_uns_q;
    logic [INT_W:0] s2_mag_q;
    logic [1:0]     s2_rm_q;

    // ---------------- S3: round/range ----------------
    logic             inc;
    logic [INT_W+1:0] rmag;
    logic [INT_W-1:0] d_d;
    logic             lost_d, den_d, inv_d;

    always_comb begin
        inc = 1'b0;
        case (s2_rm_q)
            RM_RNE:  inc = s2_g_q & (s2_s_q | s2_mag_q[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = s2_sign_q & (s2_g_q | s2_s_q);
            RM_RUP:  inc = ~s2_sign_q & (s2_g_q | s2_s_q);
            default: inc = 1'b0;
        endcase
    end

    assign rmag = {1'b0, s2_mag_q} + {{(INT_W+1){1'b0}}, inc};

    always_comb begin
        d_d    = '0;
        inv_d  = 1'b0;
        lost_d = 1'b0;
        den_d  = s2_sub_q;
        if (s2_nan_q) begin
            inv_d = 1'b1;
            d_d   = s2_uns_q ? '0 : SMIN;
        end else if (s2_inf_q || s2_ovf_q) begin
            inv_d = 1'b1;
            if (s2_sign_q) d_d = s2_uns_q ? '0 : SMIN;
            else           d_d = s2_uns_q ? '1 : SMAX;
        end else if (!s2_zero_q) begin
            lost_d = s2_g_q | s2_s_q;
            if (s2_uns_q) begin
                // Negative operands are legal only when they round to zero.
                if (s2_sign_q) begin
                    inv_d = (rmag != '0);
                end else if (rmag[INT_W+1:INT_W] != 2'b00) begin
                    inv_d = 1'b1;
                    d_d   = '1;
                end else begin
                    d_d = rmag[INT_W-1:0];
                end
            end else if (s2_sign_q) begin
                if (rmag > {2'b00, SMIN}) begin
                    inv_d = 1'b1;
                    d_d   = SMIN;
                end else begin
                    d_d = INT_W'(0) - rmag[INT_W-1:0];
                end
            end else if (rmag > {2'b00, SMAX}) begin
                inv_d = 1'b1;
                d_d   = SMAX;
            end else begin
                d_d = rmag[INT_W-1:0];
            end
            if (inv_d) lost_d = 1'b0;
        end
    end

    logic             out_v_q, lost_q, den_q, inv_q, stk_inv_q, stk_inx_q;
    logic [INT_W-1:0] d_q;
    logic             xfer, stk_inv_d, stk_inx_d;

    assign xfer      = out_v_q & out_ready;
    assign stk_inv_d = (flag_clr ? 1'b0 : stk_inv_q) | (xfer & inv_q);
    assign stk_inx_d = (flag_clr ? 1'b0 : stk_inx_q) | (xfer & lost_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0; s1_sign_q <= 1'b0; s1_zero_q <= 1'b0; s1_sub_q <= 1'b0;
            s1_inf_q <= 1'b0; s1_nan_q <= 1'b0; s1_uns_q <= 1'b0; s1_exp_q <= '0;
            s1_sig_q <= '0; s1_rm_q <= '0;
            s2_v_q <= 1'b0; s2_sign_q <= 1'b0; s2_g_q <= 1'b0; s2_s_q <= 1'b0;
            s2_ovf_q <= 1'b0; s2_zero_q <= 1'b0; s2_sub_q <= 1'b0; s2_inf_q <= 1'b0;
            s2_nan_q <= 1'b0; s2_uns_q <= 1'b0; s2_mag_q <= '0; s2_rm_q <= '0;
            out_v_q <= 1'b0; d_q <= '0; lost_q <= 1'b0; den_q <= 1'b0; inv_q <= 1'b0;
            stk_inv_q <= 1'b0; stk_inx_q <= 1'b0;
        end else begin
            if (en) begin
                s1_v_q    <= in_valid;
                s1_sign_q <= a_sign;
                s1_zero_q <= s1_zero_d;
                s1_sub_q  <= s1_sub_d;
                s1_inf_q  <= s1_inf_d;
                s1_nan_q  <= s1_nan_d;
                s1_uns_q  <= is_unsigned;
                s1_exp_q  <= s1_exp_d;
                s1_sig_q  <= {1'b1, a_frac};
                s1_rm_q   <= rm;

                s2_v_q    <= s1_v_q;
                s2_sign_q <= s1_sign_q;
                s2_g_q    <= s2_g_d;
                s2_s_q    <= s2_s_d;
                s2_ovf_q  <= s2_ovf_d;
                s2_zero_q <= s1_zero_q;
                s2_sub_q  <= s1_sub_q;
                s2_inf_q  <= s1_inf_q;
                s2_nan_q  <= s1_nan_q;
                s2_uns_q  <= s1_uns_q;
                s2_mag_q  <= s2_mag_d;
                s2_rm_q   <= s1_rm_q;

                out_v_q <= s2_v_q;
                d_q     <= d_d;
                lost_q  <= lost_d;
                den_q   <= den_d;
                inv_q   <= inv_d;
            end
            stk_inv_q <= stk_inv_d;
            stk_inx_q <= stk_inx_d;
        end
    end

    assign out_valid      = out_v_q;
    assign d              = d_q;
    assign p_lost         = lost_q;
    assign denorm         = den_q;
    assign invalid        = inv_q;
    assign sticky_invalid = stk_inv_q;
    assign sticky_inexact = stk_inx_q;
endmodule

// File: tb/tb_f2i_pipe.sv
// Directed bench for f2i_pipe: vector tables for the default and double/64-bit
// configurations, plus backpressure, mid-flight reset and sticky-flag sequences.
module tb_f2i_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        iv_a, ir_a, ov_a, or_a, uns_a, pl_a, dn_a, inv_a, clr_a, si_a, sx_a;
    logic [31:0] a_a, d_a;
    logic [1:0]  rm_a;

    logic        iv_b, ir_b, ov_b, or_b, uns_b, pl_b, dn_b, inv_b, clr_b, si_b, sx_b;
    logic [63:0] a_b, d_b;
    logic [1:0]  rm_b;

    f2i_pipe dut_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .a(a_a), .rm(rm_a),
        .is_unsigned(uns_a), .out_valid(ov_a), .out_ready(or_a), .d(d_a), .p_lost(pl_a),
        .denorm(dn_a), .invalid(inv_a), .flag_clr(clr_a), .sticky_invalid(si_a),
        .sticky_inexact(sx_a)
    );

    f2i_pipe #(.EXP_W(11), .MAN_W(52), .INT_W(64)) dut_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .a(a_b), .rm(rm_b),
        .is_unsigned(uns_b), .out_valid(ov_b), .out_ready(or_b), .d(d_b), .p_lost(pl_b),
        .denorm(dn_b), .invalid(inv_b), .flag_clr(clr_b), .sticky_invalid(si_b),
        .sticky_inexact(sx_b)
    );

    typedef struct {
        logic [63:0] a;
        logic [1:0]  rm;
        logic        uns;
        logic [63:0] d;
        logic        pl;
        logic        dn;
        logic        inv;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    function automatic vec_t mk(input logic [63:0] a, input logic [1:0] rm, input logic uns,
                                input logic [63:0] d, input logic pl, input logic dn,
                                input logic inv);
        vec_t v;
        v.a = a; v.rm = rm; v.uns = uns; v.d = d; v.pl = pl; v.dn = dn; v.inv = inv;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Send one operand with out_ready high and compare the delivered result.
    task automatic run_vec(input bit wide, input vec_t v, input bit clr_on_out, input string tag);
        int   lat;
        logic ov;
        @(negedge clk);
        if (wide) begin
            iv_b = 1'b1; a_b = v.a; rm_b = v.rm; uns_b = v.uns;
        end else begin
            iv_a = 1'b1; a_a = v.a[31:0]; rm_a = v.rm; uns_a = v.uns;
        end
        @(posedge clk);
        @(negedge clk);
        iv_a = 1'b0;
        iv_b = 1'b0;
        lat  = 1;
        ov   = wide ? ov_b : ov_a;
        while (!ov && lat < 20) begin
            @(negedge clk);
            lat++;
            ov = wide ? ov_b : ov_a;
        end
        check({tag, ".latency"}, 64'(lat), 64'd3);
        if (wide) begin
            check({tag, ".d"}, d_b, v.d);
            check({tag, ".p_lost"}, {63'd0, pl_b}, {63'd0, v.pl});
            check({tag, ".denorm"}, {63'd0, dn_b}, {63'd0, v.dn});
            check({tag, ".invalid"}, {63'd0, inv_b}, {63'd0, v.inv});
        end else begin
            check({tag, ".d"}, {32'd0, d_a}, {32'd0, v.d[31:0]});
            check({tag, ".p_lost"}, {63'd0, pl_a}, {63'd0, v.pl});
            check({tag, ".denorm"}, {63'd0, dn_a}, {63'd0, v.dn});
            check({tag, ".invalid"}, {63'd0, inv_a}, {63'd0, v.inv});
        end
        if (clr_on_out) clr_a = 1'b1;
        @(posedge clk);
        #1;
        clr_a = 1'b0;
    endtask

    vec_t v32[$];
    vec_t v64[$];
    logic [31:0] bp_in [6];

    initial begin
        // rm: 0 RNE, 1 RTZ, 2 RDN, 3 RUP
        v32.push_back(mk(64'h40490FDB, 2'd0, 1'b0, 64'h00000003, 1, 0, 0)); // pi
        v32.push_back(mk(64'h40200000, 2'd0, 1'b0, 64'h00000002, 1, 0, 0)); // 2.5 tie to even
        v32.push_back(mk(64'h3FC00000, 2'd0, 1'b0, 64'h00000002, 1, 0, 0)); // 1.5
        v32.push_back(mk(64'h3FC00000, 2'd1, 1'b0, 64'h00000001, 1, 0, 0));
        v32.push_back(mk(64'h3FC00000, 2'd2, 1'b0, 64'h00000001, 1, 0, 0));
        v32.push_back(mk(64'h3FC00000, 2'd3, 1'b0, 64'h00000002, 1, 0, 0));
        v32.push_back(mk(64'hBFC00000, 2'd1, 1'b0, 64'hFFFFFFFF, 1, 0, 0)); // -1.5
        v32.push_back(mk(64'hBFC00000, 2'd2, 1'b0, 64'hFFFFFFFE, 1, 0, 0));
        v32.push_back(mk(64'hBFC00000, 2'd3, 1'b0, 64'hFFFFFFFF, 1, 0, 0));
        v32.push_back(mk(64'hC0200000, 2'd0, 1'b0, 64'hFFFFFFFE, 1, 0, 0)); // -2.5
        v32.push_back(mk(64'h4F000000, 2'd0, 1'b0, 64'h7FFFFFFF, 0, 0, 1)); // 2^31
        v32.push_back(mk(64'h4F000000, 2'd0, 1'b1, 64'h80000000, 0, 0, 0));
        v32.push_back(mk(64'hCF000000, 2'd0, 1'b0, 64'h80000000, 0, 0, 0)); // -2^31
        v32.push_back(mk(64'hCF000001, 2'd0, 1'b0, 64'h80000000, 0, 0, 1));
        v32.push_back(mk(64'h4EFFFFFF, 2'd0, 1'b0, 64'h7FFFFF80, 0, 0, 0));
        v32.push_back(mk(64'h4F800000, 2'd0, 1'b1, 64'hFFFFFFFF, 0, 0, 1)); // 2^32
        v32.push_back(mk(64'h50000000, 2'd0, 1'b0, 64'h7FFFFFFF, 0, 0, 1)); // 2^33
        v32.push_back(mk(64'h7FC00000, 2'd0, 1'b0, 64'h80000000, 0, 0, 1)); // NaN
        v32.push_back(mk(64'h7FC00000, 2'd0, 1'b1, 64'h00000000, 0, 0, 1));
        v32.push_back(mk(64'h7F800000, 2'd0, 1'b0, 64'h7FFFFFFF, 0, 0, 1)); // +inf
        v32.push_back(mk(64'h7F800000, 2'd0, 1'b1, 64'hFFFFFFFF, 0, 0, 1));
        v32.push_back(mk(64'hFF800000, 2'd0, 1'b0, 64'h80000000, 0, 0, 1)); // -inf
        v32.push_back(mk(64'hFF800000, 2'd0, 1'b1, 64'h00000000, 0, 0, 1));
        v32.push_back(mk(64'hBF800000, 2'd0, 1'b1, 64'h00000000, 0, 0, 1)); // -1.0 unsigned
        v32.push_back(mk(64'hBE800000, 2'd0, 1'b1, 64'h00000000, 1, 0, 0)); // -0.25 unsigned
        v32.push_back(mk(64'h3F400000, 2'd0, 1'b0, 64'h00000001, 1, 0, 0)); // 0.75
        v32.push_back(mk(64'h3E000000, 2'd0, 1'b0, 64'h00000000, 1, 0, 0)); // 0.125
        v32.push_back(mk(64'h3E000000, 2'd3, 1'b0, 64'h00000001, 1, 0, 0));
        v32.push_back(mk(64'h42F60000, 2'd0, 1'b0, 64'h0000007B, 0, 0, 0)); // 123
        v32.push_back(mk(64'h00000001, 2'd3, 1'b0, 64'h00000001, 1, 1, 0)); // subnormal
        v32.push_back(mk(64'h00000001, 2'd0, 1'b0, 64'h00000000, 1, 1, 0));
        v32.push_back(mk(64'h80000001, 2'd2, 1'b1, 64'h00000000, 0, 1, 1));
        v32.push_back(mk(64'h80000001, 2'd2, 1'b0, 64'hFFFFFFFF, 1, 1, 0));
        v32.push_back(mk(64'h00000000, 2'd0, 1'b0, 64'h00000000, 0, 0, 0)); // +0
        v32.push_back(mk(64'h80000000, 2'd0, 1'b1, 64'h00000000, 0, 0, 0)); // -0

        v64.push_back(mk(64'h4004000000000000, 2'd0, 1'b0, 64'h0000000000000002, 1, 0, 0));
        v64.push_back(mk(64'hBFF8000000000000, 2'd2, 1'b0, 64'hFFFFFFFFFFFFFFFE, 1, 0, 0));
        v64.push_back(mk(64'h43E0000000000000, 2'd0, 1'b0, 64'h7FFFFFFFFFFFFFFF, 0, 0, 1));
        v64.push_back(mk(64'h43E0000000000000, 2'd0, 1'b1, 64'h8000000000000000, 0, 0, 0));
        v64.push_back(mk(64'h7FF8000000000000, 2'd0, 1'b0, 64'h8000000000000000, 0, 0, 1));
        v64.push_back(mk(64'h0000000000000001, 2'd3, 1'b0, 64'h0000000000000001, 1, 1, 0));

        bp_in = '{32'h3F800000, 32'h40000000, 32'h40400000,
                  32'h40800000, 32'h40A00000, 32'h40C00000};

        // Clock/reset
        rst = 1'b1;
        iv_a = 1'b0; a_a = '0; rm_a = '0; uns_a = 1'b0; or_a = 1'b1; clr_a = 1'b0;
        iv_b = 1'b0; a_b = '0; rm_b = '0; uns_b = 1'b0; or_b = 1'b1; clr_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset.out_valid", {63'd0, ov_a}, 64'd0);
        check("reset.in_ready", {63'd0, ir_a}, 64'd1);
        check("reset.d", {32'd0, d_a}, 64'd0);
        check("reset.flags", {61'd0, pl_a, dn_a, inv_a}, 64'd0);
        check("reset.sticky", {62'd0, si_a, sx_a}, 64'd0);

        // Directed tables
        for (int i = 0; i < v32.size(); i++)
            run_vec(1'b0, v32[i], 1'b0, $sformatf("v32[%0d]", i));
        for (int i = 0; i < v64.size(); i++)
            run_vec(1'b1, v64[i], 1'b0, $sformatf("v64[%0d]", i));

        // Sticky flags
        @(negedge clk); clr_a = 1'b1;
        @(negedge clk); clr_a = 1'b0;
        check("sticky.clear_idle", {62'd0, si_a, sx_a}, 64'd0);
        run_vec(1'b0, mk(64'h40200000, 2'd0, 1'b0, 64'h2, 1, 0, 0), 1'b0, "sticky.2p5");
        check("sticky.after_2p5", {62'd0, si_a, sx_a}, 64'b01);
        run_vec(1'b0, mk(64'h7FC00000, 2'd0, 1'b0, 64'h80000000, 0, 0, 1), 1'b0, "sticky.nan");
        check("sticky.after_nan", {62'd0, si_a, sx_a}, 64'b11);
        @(negedge clk); clr_a = 1'b1;
        @(negedge clk); clr_a = 1'b0;
        check("sticky.clear_no_xfer", {62'd0, si_a, sx_a}, 64'd0);
        run_vec(1'b0, mk(64'h7FC00000, 2'd0, 1'b0, 64'h80000000, 0, 0, 1), 1'b1, "sticky.nan_clr");
        check("sticky.set_wins", {62'd0, si_a, sx_a}, 64'b10);

        // Backpressure: 6 back-to-back operands, out_ready low for cycles 4..8
        begin
            int          sent = 0;
            int          got = 0;
            int          dup = 0;
            logic        prev_stall = 1'b0;
            logic [31:0] prev_d = '0;
            for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
                @(negedge clk);
                iv_a  = (sent < 6);
                a_a   = (sent < 6) ? bp_in[sent] : 32'h0;
                rm_a  = 2'd1;
                uns_a = 1'b0;
                or_a  = !(cyc >= 4 && cyc <= 8);
                #1;
                if (prev_stall) begin
                    check("bp.hold_d", {32'd0, d_a}, {32'd0, prev_d});
                    check("bp.hold_valid", {63'd0, ov_a}, 64'd1);
                end
                if (ov_a && !or_a) check("bp.in_ready_low", {63'd0, ir_a}, 64'd0);
                if (iv_a && ir_a) begin
                    exp_q.push_back(32'(sent + 1));
                    sent++;
                end
                if (ov_a && or_a) begin
                    if (exp_q.size() == 0) check("bp.unexpected_out", 64'd1, 64'd0);
                    else check("bp.d", {32'd0, d_a}, {32'd0, exp_q.pop_front()});
                    got++;
                end
                prev_stall = ov_a && !or_a;
                prev_d     = d_a;
            end
            @(negedge clk);
            iv_a = 1'b0;
            or_a = 1'b1;
            check("bp.sent", 64'(sent), 64'd6);
            check("bp.received", 64'(got), 64'd6);
            repeat (5) begin
                @(negedge clk);
                if (ov_a) dup++;
            end
            check("bp.no_duplicates", 64'(dup), 64'd0);
        end

        // Reset with two operands in flight
        begin
            int stale = 0;
            @(negedge clk); iv_a = 1'b1; a_a = 32'h3F800000; rm_a = 2'd0; uns_a = 1'b0;
            @(negedge clk); a_a = 32'h40000000;
            @(negedge clk); iv_a = 1'b0; rst = 1'b1;
            @(negedge clk); rst = 1'b0;
            check("rst_flight.out_valid", {63'd0, ov_a}, 64'd0);
            check("rst_flight.in_ready", {63'd0, ir_a}, 64'd1);
            check("rst_flight.d", {32'd0, d_a}, 64'd0);
            repeat (6) begin
                @(negedge clk);
                if (ov_a) stale++;
            end
            check("rst_flight.no_stale", 64'(stale), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
